// File: rtl/led_pio_pkg.sv
// Shared definitions for the LED PIO peripheral: register map, channel modes
// and CTRL bit positions.
package led_pio_pkg;

  localparam logic [4:0] ADDR_CTRL      = 5'd0;
  localparam logic [4:0] ADDR_DATA      = 5'd1;
  localparam logic [4:0] ADDR_BLINK     = 5'd2;
  localparam logic [4:0] ADDR_MODE      = 5'd3;
  localparam logic [4:0] ADDR_DUTY_BASE = 5'd4;

  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_POL_BIT = 1;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'b00,
    MODE_BLINK  = 2'b01,
    MODE_PWM    = 2'b10,
    MODE_OFF    = 2'b11
  } led_mode_e;

endpackage

// File: rtl/led_pio_chan.sv
// One LED channel: selects the on/off source for its mode, applies enable and
// polarity, and registers the pin drive.
module led_pio_chan
  import led_pio_pkg::*;
#(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  led_mode_e           mode_i,
  input  logic                data_i,
  input  logic [PWM_BITS-1:0] duty_i,
  input  logic [PWM_BITS-1:0] pwm_cnt_i,
  input  logic                phase_i,
  input  logic                en_i,
  input  logic                pol_i,
  output logic                led_o
);

  logic on;
  logic led_d;
  logic led_q;

  always_comb begin
    on = 1'b0;
    case (mode_i)
      MODE_STATIC: on = data_i;
      MODE_BLINK:  on = data_i & phase_i;
      MODE_PWM:    on = (pwm_cnt_i < duty_i);
      default:     on = 1'b0;
    endcase
    // A disabled block parks every pin at its inactive level.
    led_d = en_i ? (on ^ pol_i) : pol_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) led_q <= 1'b0;
    else        led_q <= led_d;
  end

  assign led_o = led_q;

endmodule

// File: rtl/led_pio_ctrl.sv
// Avalon-MM LED driver: register file, shared PWM/blink timebase and one
// led_pio_chan per output pin.
module led_pio_ctrl
  import led_pio_pkg::*;
#(
  parameter int NUM_CH     = 8,
  parameter int PWM_BITS   = 8,
  parameter int BLINK_BITS = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4:0]        avs_address,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic              avs_read,
  output logic [31:0]       avs_readdata,
  output logic [NUM_CH-1:0] led_out
);

  logic [1:0]            ctrl_q;
  logic [NUM_CH-1:0]     data_q;
  logic [BLINK_BITS-1:0] period_q;
  logic [2*NUM_CH-1:0]   mode_q;
  logic [PWM_BITS-1:0]   duty_q [NUM_CH];

  logic [PWM_BITS-1:0]   pwm_cnt_q;
  logic [BLINK_BITS-1:0] blink_cnt_q;
  logic                  phase_q;
  logic [31:0]           rdata_d;
  logic [31:0]           rdata_q;

  logic en;
  logic pol;
  logic wr_blink;
  logic unused_wdata;

  assign en           = ctrl_q[CTRL_EN_BIT];
  assign pol          = ctrl_q[CTRL_POL_BIT];
  assign wr_blink     = avs_write && (avs_address == ADDR_BLINK);
  assign unused_wdata = ^avs_writedata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q   <= '0;
      data_q   <= '0;
      period_q <= '0;
      mode_q   <= '0;
      for (int i = 0; i < NUM_CH; i++) duty_q[i] <= '0;
    end else if (avs_write) begin
      case (avs_address)
        ADDR_CTRL:  ctrl_q   <= avs_writedata[1:0];
        ADDR_DATA:  data_q   <= avs_writedata[NUM_CH-1:0];
        ADDR_BLINK: period_q <= avs_writedata[BLINK_BITS-1:0];
        ADDR_MODE:  mode_q   <= avs_writedata[2*NUM_CH-1:0];
        default:    ;
      endcase
      for (int i = 0; i < NUM_CH; i++)
        if (avs_address == ADDR_DUTY_BASE + 5'(i))
          duty_q[i] <= avs_writedata[PWM_BITS-1:0];
    end
  end

  // Readback mux; the registered sample sees pre-write contents on a
  // simultaneous read and write.
  always_comb begin
    rdata_d = '0;
    case (avs_address)
      ADDR_CTRL:  rdata_d[1:0]            = ctrl_q;
      ADDR_DATA:  rdata_d[NUM_CH-1:0]     = data_q;
      ADDR_BLINK: rdata_d[BLINK_BITS-1:0] = period_q;
      ADDR_MODE:  rdata_d[2*NUM_CH-1:0]   = mode_q;
      default:    ;
    endcase
    for (int i = 0; i < NUM_CH; i++)
      if (avs_address == ADDR_DUTY_BASE + 5'(i))
        rdata_d[PWM_BITS-1:0] = duty_q[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        rdata_q <= '0;
    else if (avs_read) rdata_q <= rdata_d;
  end

  // Shared timebase; a blink-period write restarts the count but keeps phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q   <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else if (!en) begin
      pwm_cnt_q   <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
      if (wr_blink) begin
        blink_cnt_q <= '0;
      end else if (blink_cnt_q == period_q) begin
        blink_cnt_q <= '0;
        phase_q     <= ~phase_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + BLINK_BITS'(1);
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    led_pio_chan #(.PWM_BITS(PWM_BITS)) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .mode_i    (led_mode_e'(mode_q[2*i +: 2])),
      .data_i    (data_q[i]),
      .duty_i    (duty_q[i]),
      .pwm_cnt_i (pwm_cnt_q),
      .phase_i   (phase_q),
      .en_i      (en),
      .pol_i     (pol),
      .led_o     (led_out[i])
    );
  end

  assign avs_readdata = rdata_q;

endmodule

// File: tb/tb_led_pio_ctrl.sv
// Self-checking bench for led_pio_ctrl: an elapsed-time model of the LED
// outputs and readback, compared every cycle, plus directed literal checks.
module tb_led_pio_ctrl;

  localparam int NUM_CH     = 8;
  localparam int PWM_BITS   = 8;
  localparam int BLINK_BITS = 24;

  logic              clk;
  logic              rst_n;
  logic [4:0]        avs_address;
  logic              avs_write;
  logic [31:0]       avs_writedata;
  logic              avs_read;
  logic [31:0]       avs_readdata;
  logic [NUM_CH-1:0] led_out;

  int vectors     = 0;
  int miscompares = 0;

  led_pio_ctrl #(
    .NUM_CH(NUM_CH), .PWM_BITS(PWM_BITS), .BLINK_BITS(BLINK_BITS)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .avs_address   (avs_address),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_read      (avs_read),
    .avs_readdata  (avs_readdata),
    .led_out       (led_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [1:0]            mCtrl;
  logic [NUM_CH-1:0]     mData;
  logic [BLINK_BITS-1:0] mPeriod;
  logic [2*NUM_CH-1:0]   mMode;
  logic [PWM_BITS-1:0]   mDuty [NUM_CH];
  longint                enCycles;
  longint                blinkElapsed;
  logic                  phaseAtClear;
  logic [NUM_CH-1:0]     expLed;
  logic [31:0]           expRd;
  logic                  mEn, mPol, mPh, mOn, blinkWrite;
  longint                mPwm;

  function automatic logic [31:0] modelRead(input logic [4:0] a);
    logic [31:0] r;
    int ai;
    r  = '0;
    ai = int'(a);
    if (ai == 0)      r = 32'(mCtrl);
    else if (ai == 1) r = 32'(mData);
    else if (ai == 2) r = 32'(mPeriod);
    else if (ai == 3) r = 32'(mMode);
    else if (ai >= 4 && ai < 4 + NUM_CH) r = 32'(mDuty[ai-4]);
    return r;
  endfunction

  task automatic modelWrite(input logic [4:0] a, input logic [31:0] d);
    int ai;
    ai = int'(a);
    if (ai == 0)      mCtrl   = d[1:0];
    else if (ai == 1) mData   = d[NUM_CH-1:0];
    else if (ai == 2) mPeriod = d[BLINK_BITS-1:0];
    else if (ai == 3) mMode   = d[2*NUM_CH-1:0];
    else if (ai >= 4 && ai < 4 + NUM_CH) mDuty[ai-4] = d[PWM_BITS-1:0];
  endtask

  // Counters are derived from cycles elapsed since enable / last period write.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mCtrl = '0; mData = '0; mPeriod = '0; mMode = '0;
      for (int i = 0; i < NUM_CH; i++) mDuty[i] = '0;
      enCycles = 0; blinkElapsed = 0; phaseAtClear = 1'b0;
      expLed = '0; expRd = '0;
    end else begin
      mEn  = mCtrl[0];
      mPol = mCtrl[1];
      mPwm = enCycles % (longint'(1) << PWM_BITS);
      mPh  = phaseAtClear ^ 1'((blinkElapsed / (longint'(mPeriod) + 1)) % 2);
      for (int c = 0; c < NUM_CH; c++) begin
        case (mMode[2*c +: 2])
          2'd0:    mOn = mData[c];
          2'd1:    mOn = mData[c] & mPh;
          2'd2:    mOn = (mPwm < longint'(mDuty[c]));
          default: mOn = 1'b0;
        endcase
        expLed[c] = mEn ? (mOn ^ mPol) : mPol;
      end
      if (avs_read) expRd = modelRead(avs_address);
      blinkWrite = avs_write && (avs_address == 5'd2);
      if (avs_write) modelWrite(avs_address, avs_writedata);
      if (!mEn) begin
        enCycles = 0; blinkElapsed = 0; phaseAtClear = 1'b0;
      end else begin
        enCycles++;
        if (blinkWrite) begin
          phaseAtClear = mPh;
          blinkElapsed = 0;
        end else begin
          blinkElapsed++;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("model led_out", 32'(led_out), 32'(expLed));
    checkOutput("model readdata", avs_readdata, expRd);
  end

  // One bus cycle: drive at a falling edge, return at the next falling edge.
  task automatic applyStimulus(input logic wr, input logic rd, input logic [4:0] addr,
                               input logic [31:0] wdata);
    @(negedge clk);
    avs_write     = wr;
    avs_read      = rd;
    avs_address   = addr;
    avs_writedata = wdata;
    @(negedge clk);
    avs_write = 1'b0;
    avs_read  = 1'b0;
  endtask

  initial begin
    int         highs;
    logic [9:0] pattern;
    rst_n = 1'b1;
    avs_address = '0; avs_write = 1'b0; avs_writedata = '0; avs_read = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int a = 0; a < 32; a++) begin
      applyStimulus(1'b0, 1'b1, 5'(a), 32'h0);
      checkOutput("reset readback", avs_readdata, 32'h0);
    end
    checkOutput("reset led_out", 32'(led_out), 32'h0);

    applyStimulus(1'b1, 1'b0, 5'd1, 32'hA5);
    applyStimulus(1'b1, 1'b0, 5'd0, 32'h1);
    @(negedge clk);
    checkOutput("static led_out", 32'(led_out), 32'hA5);
    applyStimulus(1'b1, 1'b0, 5'd0, 32'h3);
    @(negedge clk);
    checkOutput("inverted led_out", 32'(led_out), 32'h5A);

    applyStimulus(1'b1, 1'b0, 5'd0, 32'h1);
    applyStimulus(1'b1, 1'b0, 5'd3, 32'h2);
    applyStimulus(1'b1, 1'b0, 5'd4, 32'd64);
    highs = 0;
    for (int n = 0; n < 256; n++) begin
      @(negedge clk);
      if (led_out[0]) highs++;
    end
    checkOutput("pwm duty 64 high count", 32'(highs), 32'd64);
    applyStimulus(1'b1, 1'b0, 5'd4, 32'd0);
    highs = 0;
    for (int n = 0; n < 256; n++) begin
      @(negedge clk);
      if (led_out[0]) highs++;
    end
    checkOutput("pwm duty 0 high count", 32'(highs), 32'd0);

    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0);
    applyStimulus(1'b1, 1'b0, 5'd3, 32'h4);
    applyStimulus(1'b1, 1'b0, 5'd1, 32'h2);
    applyStimulus(1'b1, 1'b0, 5'd2, 32'd4);
    applyStimulus(1'b1, 1'b0, 5'd0, 32'h1);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      pattern[n] = led_out[1];
    end
    checkOutput("blink pattern", 32'(pattern), 32'(10'b11111_00000));

    applyStimulus(1'b1, 1'b0, 5'd1, 32'h0F);
    applyStimulus(1'b1, 1'b1, 5'd1, 32'hF0);
    checkOutput("read during write", avs_readdata, 32'h0F);
    applyStimulus(1'b0, 1'b1, 5'd1, 32'h0);
    checkOutput("read after write", avs_readdata, 32'hF0);
    applyStimulus(1'b1, 1'b0, 5'd31, 32'hFFFF_FFFF);
    applyStimulus(1'b0, 1'b1, 5'd31, 32'h0);
    checkOutput("unmapped readback", avs_readdata, 32'h0);
    applyStimulus(1'b0, 1'b1, 5'd1, 32'h0);
    checkOutput("data after unmapped write", avs_readdata, 32'hF0);

    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async reset led_out", 32'(led_out), 32'h0);
    checkOutput("async reset readdata", avs_readdata, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("led_out after release", 32'(led_out), 32'h0);
    for (int a = 0; a < 4 + NUM_CH; a++) begin
      applyStimulus(1'b0, 1'b1, 5'(a), 32'h0);
      checkOutput("readback after reset", avs_readdata, 32'h0);
    end
    checkOutput("led_out idle after reset", 32'(led_out), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/led_pio_ctrl.md
# led_pio_ctrl

Parametrised LED output peripheral on the Nios II Avalon-MM bus, replacing the plain PIO LED port with a multi-channel, multi-mode LED driver. Each channel is independently static, blinking, PWM-dimmed or forced off, with global enable and output polarity control. The block sits between the system interconnect and the board LED pins, with one clock domain.

## Interface
- NUM_CH, 8: LED channel count, 1..16.
- PWM_BITS, 8: PWM counter and duty width, 2..16.
- BLINK_BITS, 24: blink period counter width, 1..32.
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- avs_address  in  5  word address.
- avs_write  in  1  write strobe, single-cycle, no waitrequest.
- avs_writedata  in  32  write data, full-word writes only.
- avs_read  in  1  read strobe.
- avs_readdata  out  32  read data, valid one cycle after avs_read.
- led_out  out  NUM_CH  registered LED drive.

## Operation
- Register map:
  - 0 CTRL: bit0 EN, bit1 POL (1 = active-low LEDs).
  - 1 DATA: bits[NUM_CH-1:0].
  - 2 BLINK_PERIOD: bits[BLINK_BITS-1:0].
  - 3 MODE: 2 bits per channel, ch i at [2i+1:2i].
  - 4+i DUTY[i]: bits[PWM_BITS-1:0], for i < NUM_CH.
- Addresses outside the map ignore writes and read 0. Unimplemented bits read 0.
- MODE encoding:
  - 00 STATIC: on = DATA[i].
  - 01 BLINK: on = DATA[i] & phase.
  - 10 PWM: on = (pwm_cnt < DUTY[i]).
  - 11 OFF: on = 0.
- led_out[i] = EN ? (on ^ POL) : POL.
- PWM counter:
  - Free-running 0..2^PWM_BITS-1 while EN=1; wraps to 0.
  - DUTY=0 gives always off. DUTY=max gives on for 2^PWM_BITS-1 of every 2^PWM_BITS cycles. Full-on uses STATIC.
- Blink:
  - Counter runs 0..BLINK_PERIOD while EN=1.
  - On cnt==BLINK_PERIOD, cnt returns to 0 and phase toggles.
  - Half-period is BLINK_PERIOD+1 cycles. BLINK_PERIOD=0 toggles phase every cycle.
- Writing BLINK_PERIOD clears the blink counter to 0; phase is unchanged.
- EN=0 holds pwm_cnt, blink cnt and phase at 0. Counters restart from 0 on re-enable.
- Reset: all registers 0, counters 0, phase 0, avs_readdata 0, led_out all 0.

## Timing
- Write sampled at rising edge k; register updated at edge k.
- led_out reflects the new value at edge k+1, so it is visible 2 cycles after the strobe.
- Read sampled at edge k; avs_readdata valid after edge k and held until the next read.
- Fixed read latency is 1; no waitrequest.
- Read and write to the same address in one cycle: read returns the old value.
- All outputs are registered; no combinational path from the bus to led_out.
- Reset asserted mid-operation immediately forces every register and output to its reset value, asynchronously. Release is synchronous to clk at the system level.

## Structure
- Package led_pio_pkg holds:
  - register address constants CTRL/DATA/BLINK/MODE/DUTY_BASE;
  - mode enum (STATIC, BLINK, PWM, OFF);
  - the CTRL bit index constants.
- Sub-module led_pio_chan, instantiated NUM_CH times:
  - inputs: mode, data bit, duty, pwm_cnt, phase, EN, POL;
  - output: registered led bit.
- Shared pwm_cnt and blink counter live in the top level.

## Test plan
- Reset, then read all addresses -> all 0, led_out=0x00.
- Write CTRL=1, MODE=0, DATA=0xA5 -> led_out=0xA5 two cycles after the write. Write CTRL=3 -> led_out=0x5A.
- CTRL=1, MODE ch0=PWM, DUTY[0]=64, PWM_BITS=8 -> led_out[0] high exactly 64 of every 256 cycles. DUTY[0]=0 gives never high.
- MODE ch1=BLINK, DATA[1]=1, BLINK_PERIOD=4 -> led_out[1] alternates 5 cycles low, 5 cycles high, starting low.
- Read and write DATA in the same cycle (old 0x0F, new 0xF0) -> readdata=0x0F. The next read returns 0xF0. Write to address 31 -> no register change, readback 0.
- Assert rst_n mid-blink with EN=1 -> led_out=0 and all registers 0 without waiting for a clk edge. After release, outputs stay 0 until CTRL is written.
